// File: rtl/dlbf_data_pkg.sv
// Shared types, default widths and Gray helper for the BRAM read-address generator.
package dlbf_data_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W_DEF  = 12;

  // Gray caveat: the wrap rollover_addr -> 0 flips more than one Gray bit unless
  // rollover_addr+1 is a power of two. The CDC consumer treats the address only
  // as a progress pointer, so a multi-bit step on wrap is tolerated.
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/dlbf_data_addr_ch.sv
// One read channel: IDLE/RUN/DONE sequencer, beat/block counters, wrapping
// address and its registered Gray copy.
module dlbf_data_addr_ch
  import dlbf_data_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              go_i,
  input  logic              go_rise_i,
  input  logic              cfg_zero_i,
  input  logic [CNT_W-1:0]  niter_i,
  input  logic [CNT_W-1:0]  block_size_i,
  input  logic [ADDR_W-1:0] rollover_i,
  input  logic              adv_i,
  output logic              valid_o,
  output logic              last_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] gray_o
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  ch_state_e             state_q, state_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [CNT_W-1:0]      iter_q, iter_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     gray_q, gray_d;
  logic [GRAY_MAX_W-1:0] gray_w;
  logic                  blk_end;

  assign blk_end = (beat_q == block_size_i - CNT_ONE);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    iter_d  = iter_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go_rise_i) state_d = cfg_zero_i ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        // go low aborts, even when it coincides with the final beat
        if (!go_i) begin
          state_d = ST_IDLE;
          beat_d  = '0;
          iter_d  = '0;
          addr_d  = '0;
        end else if (adv_i) begin
          addr_d = (addr_q == rollover_i) ? '0 : addr_q + ADDR_ONE;
          if (blk_end) begin
            beat_d = '0;
            iter_d = iter_q + CNT_ONE;
            if (iter_q == niter_i - CNT_ONE) state_d = ST_DONE;
          end else begin
            beat_d = beat_q + CNT_ONE;
          end
        end
      end
      ST_DONE: begin
        if (!go_i) begin
          state_d = ST_IDLE;
          beat_d  = '0;
          iter_d  = '0;
          addr_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    gray_w = bin2gray(GRAY_MAX_W'(addr_d));
    gray_d = gray_w[ADDR_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      iter_q  <= '0;
      addr_q  <= '0;
      gray_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      iter_q  <= iter_d;
      addr_q  <= addr_d;
      gray_q  <= gray_d;
    end
  end

  assign valid_o = (state_q == ST_RUN);
  assign last_o  = (state_q == ST_RUN) && blk_end;
  assign done_o  = (state_q == ST_DONE);
  assign addr_o  = addr_q;
  assign gray_o  = gray_q;

endmodule

// File: rtl/dlbf_data_addr_gen.sv
// N-channel BRAM read-address generator: go edge detect, config latch shared by
// all channels, and the all_done reduction.
module dlbf_data_addr_gen
  import dlbf_data_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     m_axis_clk,
  input  logic                     m_axis_aresetn,
  input  logic                     go,
  input  logic [CNT_W-1:0]         niter,
  input  logic [CNT_W-1:0]         block_size,
  input  logic [ADDR_W-1:0]        rollover_addr,
  input  logic [NUM_CH-1:0]        ch_adv,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_last,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     all_done,
  output logic [NUM_CH*ADDR_W-1:0] addr_bin,
  output logic [NUM_CH*ADDR_W-1:0] addr_gray
);

  logic              go_q;
  logic              go_rise;
  logic              cfg_zero;
  logic [CNT_W-1:0]  niter_q;
  logic [CNT_W-1:0]  block_size_q;
  logic [ADDR_W-1:0] rollover_q;
  logic              all_done_q;

  assign go_rise  = go & ~go_q;
  assign cfg_zero = (niter == '0) || (block_size == '0);

  // go_q resets high so a go level still asserted across reset release is not
  // mistaken for a fresh start; go must drop and rise again.
  always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      go_q         <= 1'b1;
      niter_q      <= '0;
      block_size_q <= '0;
      rollover_q   <= '0;
      all_done_q   <= 1'b0;
    end else begin
      go_q       <= go;
      all_done_q <= &ch_done;
      if (go_rise) begin
        niter_q      <= niter;
        block_size_q <= block_size;
        rollover_q   <= rollover_addr;
      end
    end
  end

  assign all_done = all_done_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    dlbf_data_addr_ch #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk_i        (m_axis_clk),
      .rst_ni       (m_axis_aresetn),
      .go_i         (go),
      .go_rise_i    (go_rise),
      .cfg_zero_i   (cfg_zero),
      .niter_i      (niter_q),
      .block_size_i (block_size_q),
      .rollover_i   (rollover_q),
      .adv_i        (ch_adv[k]),
      .valid_o      (ch_valid[k]),
      .last_o       (ch_last[k]),
      .done_o       (ch_done[k]),
      .addr_o       (addr_bin[k*ADDR_W +: ADDR_W]),
      .gray_o       (addr_gray[k*ADDR_W +: ADDR_W])
    );
  end

endmodule

// File: tb/tb_dlbf_data_addr_gen.sv
// Directed bench for dlbf_data_addr_gen with an address scoreboard on channel 0.
module tb_dlbf_data_addr_gen;

  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int CW  = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              go;
  logic [CW-1:0]     niter;
  logic [CW-1:0]     block_size;
  logic [AW-1:0]     rollover_addr;
  logic [NCH-1:0]    ch_adv;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_last;
  logic [NCH-1:0]    ch_done;
  logic              all_done;
  logic [NCH*AW-1:0] addr_bin;
  logic [NCH*AW-1:0] addr_gray;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] sb_q[$];

  dlbf_data_addr_gen #(.NUM_CH(NCH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .m_axis_clk     (clk),
    .m_axis_aresetn (rst_n),
    .go             (go),
    .niter          (niter),
    .block_size     (block_size),
    .rollover_addr  (rollover_addr),
    .ch_adv         (ch_adv),
    .ch_valid       (ch_valid),
    .ch_last        (ch_last),
    .ch_done        (ch_done),
    .all_done       (all_done),
    .addr_bin       (addr_bin),
    .addr_gray      (addr_gray)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a, input logic [AW-1:0] roll);
    return (a == roll) ? '0 : a + 16'd1;
  endfunction

  // Pop the expected ch0 address and compare both binary and Gray views.
  task automatic sb_check(input string tag);
    logic [AW-1:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_bin"}, addr_bin[AW-1:0], e);
      chk({tag, "_gray"}, addr_gray[AW-1:0], e ^ (e >> 1));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, ch_valid, 0);
    chk({tag, "_last"}, ch_last, 0);
    chk({tag, "_done"}, ch_done, 0);
    chk({tag, "_all_done"}, all_done, 0);
    chk({tag, "_addr"}, addr_bin, 0);
    chk({tag, "_gray"}, addr_gray, 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    int cnt[NCH];
    logic [NCH-1:0] seen;
    logic [NCH-1:0] adv;
    int all_cyc;
    bit fin;

    rst_n = 1'b0; go = 1'b0; niter = '0; block_size = '0;
    rollover_addr = '0; ch_adv = '0;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(); step();
    chk("idle_valid", ch_valid, 0);

    // Basic run on channel 0
    niter = 12'd2; block_size = 12'd3; rollover_addr = 16'hFFFF; go = 1'b1;
    step();
    chk("basic_valid", ch_valid, 4'hF);
    chk("basic_addr0", addr_bin[AW-1:0], 0);
    a = '0;
    for (int i = 0; i < 6; i++) begin
      chk("basic_last", ch_last[0], (i % 3) == 2);
      a = nxt(a, rollover_addr);
      sb_q.push_back(a);
      ch_adv = 4'b0001;
      step();
      sb_check("basic");
    end
    ch_adv = '0;
    chk("basic_done", ch_done, 4'b0001);
    chk("basic_valid_after", ch_valid, 4'b1110);
    chk("basic_all_done", all_done, 0);
    go = 1'b0;
    step();
    chk("basic_clr_done", ch_done, 0);
    chk("basic_clr_addr", addr_bin, 0);

    // Rollover at 4 across 12 beats
    niter = 12'd1; block_size = 12'd12; rollover_addr = 16'd4; go = 1'b1;
    step();
    a = '0;
    for (int i = 0; i < 12; i++) begin
      chk("roll_last", ch_last[0], i == 11);
      a = nxt(a, 16'd4);
      sb_q.push_back(a);
      ch_adv = 4'b0001;
      step();
      sb_check("roll");
    end
    ch_adv = '0;
    chk("roll_done", ch_done[0], 1);
    step();
    chk("roll_hold", addr_bin[AW-1:0], 16'd2);
    go = 1'b0;
    step();

    // Zero configuration goes straight to DONE
    niter = 12'd0; block_size = 12'd3; go = 1'b1;
    step();
    chk("zero_n_done", ch_done, 4'hF);
    chk("zero_n_valid", ch_valid, 0);
    step();
    chk("zero_n_valid2", ch_valid, 0);
    chk("zero_n_all_done", all_done, 1);
    go = 1'b0;
    step();
    chk("zero_n_clr", ch_done, 0);
    niter = 12'd2; block_size = 12'd0; go = 1'b1;
    step();
    chk("zero_b_done", ch_done, 4'hF);
    chk("zero_b_valid", ch_valid, 0);
    go = 1'b0;
    step();

    // Abort after 5 of 10 beats, then restart and abort on the final beat
    niter = 12'd2; block_size = 12'd5; rollover_addr = 16'hFFFF; go = 1'b1;
    step();
    a = '0;
    for (int i = 0; i < 5; i++) begin
      a = nxt(a, rollover_addr);
      sb_q.push_back(a);
      ch_adv = 4'b0001;
      step();
      sb_check("abort_run");
    end
    ch_adv = '0; go = 1'b0;
    step();
    chk("abort_valid", ch_valid, 0);
    chk("abort_done", ch_done, 0);
    chk("abort_addr", addr_bin, 0);
    step();
    chk("abort_done2", ch_done, 0);
    go = 1'b1;
    step();
    chk("restart_valid", ch_valid, 4'hF);
    chk("restart_addr", addr_bin[AW-1:0], 0);
    ch_adv = 4'b0001;
    for (int i = 0; i < 9; i++) step();
    chk("restart_addr9", addr_bin[AW-1:0], 16'd9);
    chk("restart_last", ch_last[0], 1);
    go = 1'b0;
    step();
    ch_adv = '0;
    chk("simul_done", ch_done, 0);
    chk("simul_valid", ch_valid, 0);
    chk("simul_addr", addr_bin, 0);

    // Independent channels with random stalls
    niter = 12'd3; block_size = 12'd4; go = 1'b1;
    step();
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    seen = '0; all_cyc = -1; fin = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_done[c] && !seen[c]) begin
          chk($sformatf("indep_beats_ch%0d", c), cnt[c], 12);
          seen[c] = 1'b1;
        end
      end
      if (seen == 4'hF && all_cyc < 0) begin
        chk("indep_all_done_early", all_done, 0);
        all_cyc = cyc;
      end else if (all_cyc >= 0 && cyc == all_cyc + 1) begin
        chk("indep_all_done", all_done, 1);
        fin = 1'b1;
      end
      adv = NCH'($urandom);
      for (int c = 0; c < NCH; c++) if (adv[c] && ch_valid[c]) cnt[c]++;
      ch_adv = adv;
      step();
    end
    if (!fin) chk("indep_timeout", 0, 1);
    ch_adv = '0; go = 1'b0;
    step();

    // Asynchronous reset mid-run
    niter = 12'd2; block_size = 12'd3; go = 1'b1;
    step();
    ch_adv = 4'b0001;
    step(); step();
    ch_adv = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("areset");
    #3 rst_n = 1'b1;
    step(); step(); step();
    chk("post_rst_valid", ch_valid, 0);
    chk("post_rst_done", ch_done, 0);
    go = 1'b0;
    step();
    go = 1'b1;
    step();
    chk("post_rst_restart", ch_valid, 4'hF);
    go = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dlbf_data_addr_gen.md
Name: dlbf_data_addr_gen

Overview:
- Parametrised N-channel BRAM read-address generator and sequencer. It runs entirely in the m_axis_clk domain.
- Per channel: the read address advances on each accepted AXIS beat, wraps at a rollover address, and marks block boundaries with tlast.
- A channel asserts done after niter blocks. Each address is also emitted as registered Gray code for a downstream Gray-code CDC back to the BRAM domain.
- Generalises the fixed 4-channel, 16-bit done/address path to NUM_CH channels with configurable widths.

Parameters:
- NUM_CH, 4, number of independent read channels (1-16).
- ADDR_W, 16, BRAM address width.
- CNT_W, 12, width of the niter and block_size counters.

Ports:
- m_axis_clk  in  1  single clock for the block.
- m_axis_aresetn  in  1  asynchronous active-low reset; deassertion synchronised externally.
- go  in  1  level start/abort, already synchronised into m_axis_clk.
- niter  in  CNT_W  number of blocks per run.
- block_size  in  CNT_W  beats per block.
- rollover_addr  in  ADDR_W  last valid address; the address after it is 0.
- ch_adv  in  NUM_CH  per-channel beat accepted (tvalid & tready).
- ch_valid  out  NUM_CH  channel in RUN; drives tvalid.
- ch_last  out  NUM_CH  current beat is the last of its block.
- ch_done  out  NUM_CH  channel completed its run (level).
- all_done  out  1  AND of ch_done.
- addr_bin  out  NUM_CH*ADDR_W  current address per channel; channel k occupies bits [k*ADDR_W +: ADDR_W].
- addr_gray  out  NUM_CH*ADDR_W  registered Gray code of addr_bin.

Behaviour:
- Reset (asynchronous, active-low): every state is IDLE and every counter is 0. All outputs are 0: ch_valid, ch_last, ch_done, all_done, addr_bin, addr_gray.
- Config latch: on the go rising edge (go=1 and go_q=0), every channel latches niter, block_size and rollover_addr. Input changes during a run are ignored.
- Per-channel FSM, IDLE to RUN or DONE:
  - IDLE -> RUN on go rise when niter!=0 and block_size!=0.
  - IDLE -> DONE on go rise when either is 0; this transition takes one cycle and no beats are issued.
- Per-channel FSM, RUN:
  - ch_valid=1.
  - ch_last=1 when beat_cnt==block_size-1 (combinational from registered state).
  - On ch_adv:
    - beat_cnt increments.
    - addr becomes 0 if addr==rollover_addr, else addr+1.
    - At end of block, beat_cnt clears to 0 and iter_cnt increments.
    - On the final beat (end of block and iter_cnt==niter-1), go to DONE.
  - ch_adv while not in RUN is ignored.
- Per-channel FSM, DONE:
  - ch_done=1 and ch_valid=0; addr holds its last value.
  - DONE -> IDLE when go=0; ch_done clears and counters and addr clear to 0 on the same edge.
- Abort: go falling while in RUN sends the channel to IDLE next cycle. ch_valid drops, counters clear, and ch_done never asserts.
- Restart requires go to fall and rise again. A go rise while a channel is not in IDLE is impossible by construction.
- Latency:
  - First ch_valid appears 1 cycle after the go-rise cycle.
  - addr_bin is updated 1 cycle after ch_adv.
  - addr_gray is registered alongside addr_bin, computed as next_addr ^ (next_addr>>1), with zero relative skew.
- Gray caveat: the wrap from rollover_addr to 0 changes more than one Gray bit unless rollover_addr+1 is a power of two. The consumer samples the address only as a progress pointer, so this is accepted. The caveat is documented in the pkg constants.
- Rollover: rollover_addr=0 keeps addr at 0 permanently; beats are still counted.
- Simultaneous events: a go fall in the same cycle as the final ch_adv resolves to IDLE (abort wins), so ch_done stays 0.
- Arithmetic: all comparisons are unsigned. Counters are CNT_W bits and cannot overflow, because the terminal compares are against latched non-zero values.

Decomposition:
- dlbf_data_pkg holds:
  - the state enum (ST_IDLE, ST_RUN, ST_DONE, 2 bits);
  - the default widths ADDR_W_DEF=16 and CNT_W_DEF=12;
  - the bin2gray function.
- Sub-module dlbf_data_addr_ch implements one channel: FSM, counters, address and Gray register. It is instantiated NUM_CH times in a generate loop.
- The top contains only the go edge detect, the config latch fan-out and the all_done reduction.

Test Plan:
- Basic run: niter=2, block_size=3, rollover=0xFFFF, ch_adv=1 continuous on channel 0.
  - addr_bin goes 0,1,2,3,4,5.
  - ch_last is high on beats 2 and 5.
  - ch_done rises 1 cycle after the 6th beat, and all_done stays 0 while the other channels are not done.
- Rollover: rollover=4 with 12 beats.
  - addr sequence is 0,1,2,3,4,0,1,2,3,4,0,1.
  - addr_gray equals bin^(bin>>1) every cycle.
- Zero config: niter=0 on a go rise.
  - ch_done=1 on the next cycle and ch_valid never asserts.
  - Repeat with block_size=0 for the same result.
- Abort: drop go after 5 of 10 beats.
  - ch_valid=0 next cycle, ch_done never asserts, addr=0.
  - A new go rise restarts from addr 0.
- Independent channels: NUM_CH=4 with ch_adv stalled randomly per channel.
  - Each channel reaches done after exactly niter*block_size beats.
  - all_done rises the cycle after the last channel's done.
- Reset mid-run: assert m_axis_aresetn=0 asynchronously mid-run.
  - All outputs go to 0 immediately.
  - After release with go still high, there is no restart until go toggles.
